// File: rtl/vending_fsm_param.sv
// Coin-operated vending controller. It accumulates coded coins up to a credit cap
// and vends through a held request/ack handshake. Change and refunds are paid out
// one UNIT coin per change_ack.
module vending_fsm_param #(
    parameter int PRICE      = 30,
    parameter int UNIT       = 10,
    parameter int COIN_W     = 2,
    parameter int MAX_CREDIT = 40,
    parameter int CREDIT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_code,
    input  logic                cancel,
    input  logic                vend_ack,
    input  logic                change_ack,
    output logic                coin_accept,
    output logic                coin_reject,
    output logic                vend,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   UNIT_X  = (CREDIT_W+1)'(UNIT);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(UNIT);

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic                accept_n, reject_n, vend_n, change_valid_n;
    logic [CREDIT_W:0]   sum, sum_less_price;

    // Coin code k is worth k*UNIT, widened so credit + value cannot overflow.
    function automatic logic [CREDIT_W:0] coin_value(input logic [COIN_W-1:0] code);
        return (CREDIT_W+1)'(code) * UNIT_X;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            coin_accept  <= 1'b0;
            coin_reject  <= 1'b0;
            vend         <= 1'b0;
            change_valid <= 1'b0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            coin_accept  <= accept_n;
            coin_reject  <= reject_n;
            vend         <= vend_n;
            change_valid <= change_valid_n;
        end
    end

    always_comb begin
        state_n        = state;
        credit_n       = credit;
        accept_n       = 1'b0;
        reject_n       = 1'b0;
        vend_n         = vend;
        change_valid_n = change_valid;
        sum            = {1'b0, credit} + coin_value(coin_code);
        sum_less_price = sum - PRICE_X;

        case (state)
            IDLE, COLLECT: begin
                if (cancel && state == COLLECT) begin
                    // Refund wins over a coin arriving in the same cycle.
                    reject_n       = coin_valid;
                    state_n        = CHANGE;
                    change_valid_n = 1'b1;
                end else if (coin_valid) begin
                    if (coin_code == '0 || sum > MAX_X) begin
                        reject_n = 1'b1;
                    end else begin
                        accept_n = 1'b1;
                        if (sum >= PRICE_X) begin
                            credit_n = sum_less_price[CREDIT_W-1:0];
                            state_n  = VEND;
                            vend_n   = 1'b1;
                        end else begin
                            credit_n = sum[CREDIT_W-1:0];
                            state_n  = COLLECT;
                        end
                    end
                end
            end
            VEND: begin
                reject_n = coin_valid;
                if (vend_ack) begin
                    vend_n = 1'b0;
                    if (credit != '0) begin
                        state_n        = CHANGE;
                        change_valid_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            CHANGE: begin
                reject_n = coin_valid;
                if (credit == '0) begin
                    change_valid_n = 1'b0;
                    state_n        = IDLE;
                end else if (change_ack && change_valid) begin
                    // Clamp at zero so a mis-sized credit can never wrap.
                    if (credit <= UNIT_C) begin
                        credit_n       = '0;
                        change_valid_n = 1'b0;
                        state_n        = IDLE;
                    end else begin
                        credit_n = credit - UNIT_C;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == VEND) || (state == CHANGE);

endmodule
